// File: rtl/alu_reg_unit.sv
// 4-bit combinational ALU packaged with an independent 4-bit multi-function register.
// The two halves share only the clock/reset context.
module alu_reg_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] oc,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] f,
    input  logic       cl,
    input  logic       ld,
    input  logic [3:0] in,
    input  logic       inc,
    input  logic       dec,
    input  logic       sr,
    input  logic       ir,
    input  logic       sl,
    input  logic       il,
    output logic [3:0] out
);

    logic [7:0] prod;
    logic [3:0] out_d;

    assign prod = {4'b0000, a} * {4'b0000, b};

    always_comb begin
        f = 4'b0000;
        unique case (oc)
            3'b000: f = a + b;
            3'b001: f = a - b;
            3'b010: f = prod[3:0];
            // Divide-by-zero yields zero rather than an undefined quotient.
            3'b011: f = (b == 4'd0) ? 4'd0 : a / b;
            3'b100: f = ~a;
            3'b101: f = a ^ b;
            3'b110: f = a | b;
            3'b111: f = a & b;
        endcase
    end

    // Fixed priority: clear > load > inc > dec > shift right > shift left > hold.
    always_comb begin
        out_d = out;
        if (cl) begin
            out_d = 4'd0;
        end else if (ld) begin
            out_d = in;
        end else if (inc) begin
            out_d = out + 4'd1;
        end else if (dec) begin
            out_d = out - 4'd1;
        end else if (sr) begin
            out_d = {ir, out[3:1]};
        end else if (sl) begin
            out_d = {out[2:0], il};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= 4'd0;
        end else begin
            out <= out_d;
        end
    end

endmodule

// File: tb/tb_alu_reg_unit.sv
// Scoreboard bench for alu_reg_unit: exhaustive ALU sweep plus directed and random
// register sequences checked against an arithmetic reference model.
module tb_alu_reg_unit;

    logic       clk;
    logic       rst_n;
    logic [2:0] oc;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] f;
    logic       cl;
    logic       ld;
    logic [3:0] in;
    logic       inc;
    logic       dec;
    logic       sr;
    logic       ir;
    logic       sl;
    logic       il;
    logic [3:0] out;

    typedef struct {
        int    exp;
        string tag;
    } exp_t;

    exp_t alu_q[$];
    exp_t reg_q[$];
    exp_t async_q[$];
    event alu_ev;
    event async_ev;

    int checks   = 0;
    int failures = 0;
    int model    = 0;

    alu_reg_unit dut (
        .clk  (clk),
        .rst_n(rst_n),
        .oc   (oc),
        .a    (a),
        .b    (b),
        .f    (f),
        .cl   (cl),
        .ld   (ld),
        .in   (in),
        .inc  (inc),
        .dec  (dec),
        .sr   (sr),
        .ir   (ir),
        .sl   (sl),
        .il   (il),
        .out  (out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int ref_alu(int op, int x, int y);
        case (op)
            0:       return (x + y) % 16;
            1:       return (x - y + 16) % 16;
            2:       return (x * y) % 16;
            3:       return (y == 0) ? 0 : x / y;
            4:       return 15 - x;
            5:       return x ^ y;
            6:       return x | y;
            default: return x & y;
        endcase
    endfunction

    function automatic int ref_reg(int cur, bit c, bit l, int d, bit up, bit dn,
                                   bit r, bit ri, bit lf, bit li);
        if (c)  return 0;
        if (l)  return d;
        if (up) return (cur + 1) % 16;
        if (dn) return (cur + 15) % 16;
        if (r)  return (cur / 2) + (ri ? 8 : 0);
        if (lf) return ((cur * 2) % 16) + (li ? 1 : 0);
        return cur;
    endfunction

    function automatic void compare(string tag, int got, int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, want, $time);
        end
    endfunction

    // Monitors: pop expected values whenever the DUT presents a result.
    initial begin
        forever begin
            @(alu_ev);
            if (alu_q.size() > 0) begin
                exp_t e;
                e = alu_q.pop_front();
                compare(e.tag, int'(f), e.exp);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reg_q.size() > 0) begin
                exp_t e;
                e = reg_q.pop_front();
                compare(e.tag, int'(out), e.exp);
            end
        end
    end

    initial begin
        forever begin
            @(async_ev);
            if (async_q.size() > 0) begin
                exp_t e;
                e = async_q.pop_front();
                compare(e.tag, int'(out), e.exp);
            end
        end
    end

    // want < 0 means take the reference model's prediction.
    task automatic drive(string tag, bit c, bit l, int d, bit up, bit dn,
                         bit r, bit ri, bit lf, bit li, int want);
        exp_t e;
        @(negedge clk);
        cl = c; ld = l; in = 4'(d); inc = up; dec = dn;
        sr = r; ir = ri; sl = lf; il = li;
        if (want >= 0) model = want;
        else model = ref_reg(model, c, l, d, up, dn, r, ri, lf, li);
        e.exp = model;
        e.tag = tag;
        reg_q.push_back(e);
    endtask

    task automatic alu_sweep();
        exp_t e;
        for (int op = 0; op < 8; op++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    oc = 3'(op);
                    a  = 4'(x);
                    b  = 4'(y);
                    e.exp = ref_alu(op, x, y);
                    e.tag = $sformatf("alu oc=%0d a=%0d b=%0d", op, x, y);
                    alu_q.push_back(e);
                    #2;
                    ->alu_ev;
                    #3;
                end
            end
        end
    endtask

    task automatic reg_sequence();
        exp_t e;
        // Reset held from t=0 while controls would otherwise load 15.
        rst_n = 1'b0;
        cl = 0; ld = 1; in = 4'd15; inc = 1; dec = 0; sr = 0; ir = 0; sl = 0; il = 0;
        model = 0;
        e.exp = 0;
        e.tag = "reset_overrides_ld";
        reg_q.push_back(e);
        #7;
        rst_n = 1'b1;
        drive("idle_after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("idle_hold",        0, 0, 9, 0, 0, 0, 1, 0, 1, 0);

        drive("ld_15",      0, 1, 15, 0, 0, 0, 0, 0, 0, 15);
        drive("inc_wrap",   0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
        drive("dec_wrap",   0, 0, 0,  0, 1, 0, 0, 0, 0, 15);
        drive("ld_1001",    0, 1, 9,  0, 0, 0, 0, 0, 0, 9);
        drive("sr_ir1",     0, 0, 0,  0, 0, 1, 1, 0, 0, 12);
        drive("sl_il0",     0, 0, 0,  0, 0, 0, 0, 1, 0, 8);
        drive("sl_il1",     0, 0, 0,  0, 0, 0, 0, 1, 1, 1);
        drive("cl_ld_inc",  1, 1, 7,  1, 0, 0, 0, 0, 0, 0);
        drive("ld_inc_sr",  0, 1, 6,  1, 0, 1, 0, 0, 0, 6);
        drive("ld_5",       0, 1, 5,  0, 0, 0, 0, 0, 0, 5);
        drive("inc_dec",    0, 0, 0,  1, 1, 0, 0, 0, 0, 6);
        drive("ld_0110",    0, 1, 6,  0, 0, 0, 0, 0, 0, 6);
        drive("sr_sl",      0, 0, 0,  0, 0, 1, 0, 1, 1, 3);

        for (int i = 0; i < 1000; i++) begin
            bit c, l, up, dn, r, ri, lf, li;
            int d;
            @(negedge clk);
            c  = ($urandom_range(0, 7) == 0);
            l  = ($urandom_range(0, 3) == 0);
            d  = $urandom_range(0, 15);
            up = $urandom_range(0, 1);
            dn = $urandom_range(0, 1);
            r  = $urandom_range(0, 1);
            ri = $urandom_range(0, 1);
            lf = $urandom_range(0, 1);
            li = $urandom_range(0, 1);
            cl = c; ld = l; in = 4'(d); inc = up; dec = dn;
            sr = r; ir = ri; sl = lf; il = li;
            if (i == 500) begin
                // Asynchronous reset pulse between edges.
                #2;
                rst_n = 1'b0;
                #1;
                e.exp = 0;
                e.tag = "async_reset_immediate";
                async_q.push_back(e);
                ->async_ev;
            end
            if (i == 501) begin
                #3;
                rst_n = 1'b1;
            end
            if (!rst_n) model = 0;
            else model = ref_reg(model, c, l, d, up, dn, r, ri, lf, li);
            e.exp = model;
            e.tag = $sformatf("soak_%0d", i);
            reg_q.push_back(e);
        end
    endtask

    initial begin
        oc = 3'd0;
        a  = 4'd0;
        b  = 4'd0;
        fork
            alu_sweep();
            reg_sequence();
        join
        repeat (2) @(posedge clk);
        #2;
        compare("scoreboard_drained", alu_q.size() + reg_q.size() + async_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
